backend_dest_writeback_buffer: RTL and testbench
================================================

BACKEND_DEST_WRITEBACK_BUFFER -- requirements
Module: backend_dest_writeback_buffer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- V_ID_WIDTH, `V_ID_WIDTH, global vertex id width.
- V_VALUE_WIDTH, `V_VALUE_WIDTH, vertex value width.
- ITERATION_WIDTH, `ITERATION_WIDTH, iteration id width.
- V_OFF_AWIDTH, `V_OFF_AWIDTH, local BRAM address width.
- CORE_NUM_WIDTH, `CORE_NUM_WIDTH, id-to-core shift amount.
- FIFO_AWIDTH, 4, log2 of buffer depth (DEPTH = 2^FIFO_AWIDTH).
- AFULL_MARGIN, 4, free slots at which backpressure asserts.
- MERGE_MODE, 0, tail-merge rule: 0 overwrite, 1 unsigned min, 2 unsigned max, 3 merge disabled.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock.
- rst, in, 1, reset, asynchronous, active-low.
- recv_update_v_id, in, V_ID_WIDTH, update vertex id.
- recv_update_v_value, in, V_VALUE_WIDTH, update value.
- recv_update_v_valid, in, 1, update strobe.
- recv_iteration_end, in, 1, end-of-iteration flag.
- recv_iteration_end_valid, in, 1, flag qualifier.
- recv_iteration_id, in, ITERATION_WIDTH, current iteration id.
- next_stage_full, in, 1, downstream stall.
- dest_core_full, out, 1, backpressure to upstream, registered.
- wr_vertex_bram_addr, out, V_OFF_AWIDTH, BRAM write address.
- wr_vertex_bram_data, out, V_VALUE_WIDTH, BRAM write data.
- wr_vertex_bram_valid, out, 1, write strobe.
- wr_vertex_bram_iteration_end, out, 1, iteration-end pulse.
- wr_vertex_bram_iteration_end_valid, out, 1, equals iteration_end.
- wr_vertex_bram_iteration_id, out, ITERATION_WIDTH, latched iteration id.
- fifo_count, out, FIFO_AWIDTH+1, current occupancy.
- overflow_err, out, 1, sticky drop indicator.

Function
REQ-003 Address SHALL be (recv_update_v_id >> CORE_NUM_WIDTH), truncated to V_OFF_AWIDTH LSBs.
REQ-004 The FIFO SHALL store {addr, value}, DEPTH entries, with wrapping read/write pointers of FIFO_AWIDTH bits.
REQ-005 Push: a valid update with a non-full FIFO SHALL be written at the sampling edge.
REQ-006 Merge: when MERGE_MODE!=3, the FIFO holds at least one entry, the tail address equals the incoming address, and the tail is not being popped this cycle, the tail value SHALL be combined per MERGE_MODE, with no new entry and no count change.
REQ-007 Pop SHALL occur when the FIFO is non-empty and next_stage_full=0. The popped entry SHALL drive the registered wr_vertex_bram_* with valid=1 on the next cycle. Otherwise valid=0 and addr=0, data=0.
REQ-008 Latency SHALL be: update sampled at edge N into an empty FIFO, with no stall, gives wr_vertex_bram_valid=1 in the cycle after edge N+1.
REQ-009 Simultaneous push and pop SHALL leave fifo_count unchanged; pushing into a full FIFO while popping SHALL be accepted.
REQ-010 Overflow: a push to a full FIFO without a simultaneous pop or merge SHALL be dropped and SHALL set overflow_err=1 until reset.
REQ-011 dest_core_full SHALL be registered as (fifo_count_next >= DEPTH-AFULL_MARGIN) OR next_stage_full.
REQ-012 End latch: recv_iteration_end & recv_iteration_end_valid SHALL set end_pending and capture recv_iteration_id. This SHALL apply even if recv_update_v_valid is also 1 in that cycle, in which case the update is still pushed.
REQ-013 A further end while end_pending=1 SHALL be absorbed: pending stays 1 and the id is updated.
REQ-014 End emit: when end_pending=1, the FIFO is empty, no pop occurs, and no push occurs this cycle, the block SHALL register a one-cycle iteration_end=iteration_end_valid=1 with the latched id and clear end_pending. The end pulse SHALL never coincide with wr_vertex_bram_valid=1.
REQ-015 wr_vertex_bram_iteration_id SHALL hold the last latched id between pulses.

Reset
REQ-016 rst=0 SHALL asynchronously clear all of the following: pointers, fifo_count, end_pending, latched id, overflow_err, all wr_vertex_bram_* outputs, and dest_core_full. FIFO storage contents need not be cleared.
REQ-017 Updates and ends in flight when reset is asserted SHALL be discarded. The first valid input after rst rises SHALL be processed normally.

Verification
REQ-018 Single update id=0x45, value=7, CORE_NUM_WIDTH=5, no stall -> two cycles later addr=2, data=7, valid=1 for one cycle.
REQ-019 MERGE_MODE=1, next_stage_full=1, three updates to the same id with values 9, 3, 5 -> fifo_count=1; after release, one write with data=3.
REQ-020 DEPTH=16, AFULL_MARGIN=4, stall held, 12 distinct updates -> dest_core_full=1 the cycle after the 12th; 17th distinct update -> overflow_err=1 and count=16.
REQ-021 Update and end asserted in the same cycle, id=4 -> write emitted first; iteration_end pulse with iteration_id=4 on a later cycle, exactly once.
REQ-022 rst=0 asserted mid-burst with 5 entries queued -> outputs 0 immediately; count=0; no writes or end pulse after rst rises.

Source files
------------

// File: rtl/backend_dest_writeback_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : backend_dest_writeback_buffer                                 |
// | Purpose  : Buffers vertex updates destined for the local vertex BRAM.    |
// |            Merges same-address updates at the FIFO tail, drains to the   |
// |            BRAM write port and forwards a single end-of-iteration pulse  |
// |            once every queued update ahead of it has been written.        |
// | Ports    : clk, rst (async, active-low)                                  |
// |            recv_update_*      - incoming vertex updates                  |
// |            recv_iteration_*   - end-of-iteration flag and id             |
// |            next_stage_full    - downstream stall                         |
// |            dest_core_full     - registered backpressure to upstream      |
// |            wr_vertex_bram_*   - registered BRAM write / end-pulse port   |
// |            fifo_count         - occupancy, overflow_err - sticky drop    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

`ifndef V_ID_WIDTH
`define V_ID_WIDTH 32
`endif
`ifndef V_VALUE_WIDTH
`define V_VALUE_WIDTH 32
`endif
`ifndef ITERATION_WIDTH
`define ITERATION_WIDTH 8
`endif
`ifndef V_OFF_AWIDTH
`define V_OFF_AWIDTH 10
`endif
`ifndef CORE_NUM_WIDTH
`define CORE_NUM_WIDTH 5
`endif

module backend_dest_writeback_buffer #(
  parameter int V_ID_WIDTH      = `V_ID_WIDTH,
  parameter int V_VALUE_WIDTH   = `V_VALUE_WIDTH,
  parameter int ITERATION_WIDTH = `ITERATION_WIDTH,
  parameter int V_OFF_AWIDTH    = `V_OFF_AWIDTH,
  parameter int CORE_NUM_WIDTH  = `CORE_NUM_WIDTH,
  parameter int FIFO_AWIDTH     = 4,
  parameter int AFULL_MARGIN    = 4,
  parameter int MERGE_MODE      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [V_ID_WIDTH-1:0]      recv_update_v_id,
  input  logic [V_VALUE_WIDTH-1:0]   recv_update_v_value,
  input  logic                       recv_update_v_valid,
  input  logic                       recv_iteration_end,
  input  logic                       recv_iteration_end_valid,
  input  logic [ITERATION_WIDTH-1:0] recv_iteration_id,
  input  logic                       next_stage_full,
  output logic                       dest_core_full,
  output logic [V_OFF_AWIDTH-1:0]    wr_vertex_bram_addr,
  output logic [V_VALUE_WIDTH-1:0]   wr_vertex_bram_data,
  output logic                       wr_vertex_bram_valid,
  output logic                       wr_vertex_bram_iteration_end,
  output logic                       wr_vertex_bram_iteration_end_valid,
  output logic [ITERATION_WIDTH-1:0] wr_vertex_bram_iteration_id,
  output logic [FIFO_AWIDTH:0]       fifo_count,
  output logic                       overflow_err
);

  localparam int DEPTH   = 1 << FIFO_AWIDTH;
  localparam int ENTRY_W = V_OFF_AWIDTH + V_VALUE_WIDTH;

  localparam logic [FIFO_AWIDTH:0]   c_depth       = (FIFO_AWIDTH+1)'(DEPTH);
  localparam logic [FIFO_AWIDTH:0]   c_afull_level = (FIFO_AWIDTH+1)'(DEPTH - AFULL_MARGIN);
  localparam logic [FIFO_AWIDTH:0]   c_count_one   = (FIFO_AWIDTH+1)'(1);
  localparam logic [FIFO_AWIDTH-1:0] c_ptr_one     = FIFO_AWIDTH'(1);

  // Storage: {addr, value} per entry; contents are not reset.
  logic [ENTRY_W-1:0]         r_mem [DEPTH];
  logic [FIFO_AWIDTH-1:0]     r_wptr;
  logic [FIFO_AWIDTH-1:0]     r_rptr;
  logic [FIFO_AWIDTH:0]       r_count;
  logic                       r_end_pending;
  logic [ITERATION_WIDTH-1:0] r_end_id;
  logic                       r_overflow;

  logic [V_OFF_AWIDTH-1:0]    w_addr;
  logic [FIFO_AWIDTH-1:0]     w_tail_ptr;
  logic [ENTRY_W-1:0]         w_tail_entry;
  logic [V_OFF_AWIDTH-1:0]    w_tail_addr;
  logic [V_VALUE_WIDTH-1:0]   w_tail_value;
  logic [V_VALUE_WIDTH-1:0]   w_merged_value;
  logic [ENTRY_W-1:0]         w_head_entry;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_pop;
  logic                       w_merge;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_end_in;
  logic                       w_end_emit;
  logic [FIFO_AWIDTH:0]       w_count_next;

  // The cast keeps only the local-offset LSBs of the shifted global id.
  assign w_addr       = V_OFF_AWIDTH'(recv_update_v_id >> CORE_NUM_WIDTH);

  assign w_tail_ptr   = r_wptr - c_ptr_one;
  assign w_tail_entry = r_mem[w_tail_ptr];
  assign w_tail_addr  = w_tail_entry[ENTRY_W-1:V_VALUE_WIDTH];
  assign w_tail_value = w_tail_entry[V_VALUE_WIDTH-1:0];
  assign w_head_entry = r_mem[r_rptr];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth);
  assign w_pop   = !w_empty && !next_stage_full;

  // With a single entry, a pop removes the tail itself, so merging into it
  // would lose the update; in that case a fresh entry is pushed instead.
  assign w_merge = (MERGE_MODE != 3) && recv_update_v_valid && !w_empty &&
                   (w_tail_addr == w_addr) &&
                   !(w_pop && (r_count == c_count_one));
  assign w_push  = recv_update_v_valid && !w_merge && (!w_full || w_pop);
  assign w_drop  = recv_update_v_valid && !w_merge && w_full && !w_pop;

  assign w_count_next = r_count + (FIFO_AWIDTH+1)'(w_push) - (FIFO_AWIDTH+1)'(w_pop);

  always_comb begin
    w_merged_value = recv_update_v_value;
    if (MERGE_MODE == 1) begin
      if (w_tail_value < recv_update_v_value) w_merged_value = w_tail_value;
    end else if (MERGE_MODE == 2) begin
      if (w_tail_value > recv_update_v_value) w_merged_value = w_tail_value;
    end
  end

  // An end arriving in the same cycle as a would-be emit is folded into the
  // pending one (id refreshed) rather than producing two pulses.
  assign w_end_in   = recv_iteration_end && recv_iteration_end_valid;
  assign w_end_emit = r_end_pending && w_empty && !w_pop && !w_push && !w_end_in;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_addr, recv_update_v_value};
    end else if (w_merge) begin
      r_mem[w_tail_ptr] <= {w_tail_addr, w_merged_value};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr                             <= '0;
      r_rptr                             <= '0;
      r_count                            <= '0;
      r_end_pending                      <= 1'b0;
      r_end_id                           <= '0;
      r_overflow                         <= 1'b0;
      dest_core_full                     <= 1'b0;
      wr_vertex_bram_addr                <= '0;
      wr_vertex_bram_data                <= '0;
      wr_vertex_bram_valid               <= 1'b0;
      wr_vertex_bram_iteration_end       <= 1'b0;
      wr_vertex_bram_iteration_end_valid <= 1'b0;
      wr_vertex_bram_iteration_id        <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop)  r_rptr <= r_rptr + c_ptr_one;
      r_count <= w_count_next;

      if (w_drop) r_overflow <= 1'b1;

      dest_core_full <= (w_count_next >= c_afull_level) || next_stage_full;

      wr_vertex_bram_valid <= w_pop;
      if (w_pop) begin
        wr_vertex_bram_addr <= w_head_entry[ENTRY_W-1:V_VALUE_WIDTH];
        wr_vertex_bram_data <= w_head_entry[V_VALUE_WIDTH-1:0];
      end else begin
        wr_vertex_bram_addr <= '0;
        wr_vertex_bram_data <= '0;
      end

      if (w_end_in) begin
        r_end_pending <= 1'b1;
        r_end_id      <= recv_iteration_id;
      end else if (w_end_emit) begin
        r_end_pending <= 1'b0;
      end

      wr_vertex_bram_iteration_end       <= w_end_emit;
      wr_vertex_bram_iteration_end_valid <= w_end_emit;
      if (w_end_emit) wr_vertex_bram_iteration_id <= r_end_id;
    end
  end

  assign fifo_count   = r_count;
  assign overflow_err = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_backend_dest_writeback_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_backend_dest_writeback_buffer                              |
// | Purpose  : Self-checking bench for backend_dest_writeback_buffer with a  |
// |            write/end scoreboard and one task per scenario.               |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_backend_dest_writeback_buffer;

  localparam int IDW = 16;
  localparam int VW  = 16;
  localparam int IW  = 8;
  localparam int AW  = 8;
  localparam int FAW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [IDW-1:0] recv_update_v_id = '0;
  logic [VW-1:0]  recv_update_v_value = '0;
  logic           recv_update_v_valid = 1'b0;
  logic           recv_iteration_end = 1'b0;
  logic           recv_iteration_end_valid = 1'b0;
  logic [IW-1:0]  recv_iteration_id = '0;
  logic           next_stage_full = 1'b0;
  logic           dest_core_full;
  logic [AW-1:0]  wr_vertex_bram_addr;
  logic [VW-1:0]  wr_vertex_bram_data;
  logic           wr_vertex_bram_valid;
  logic           wr_vertex_bram_iteration_end;
  logic           wr_vertex_bram_iteration_end_valid;
  logic [IW-1:0]  wr_vertex_bram_iteration_id;
  logic [FAW:0]   fifo_count;
  logic           overflow_err;

  int checks   = 0;
  int failures = 0;

  logic [AW+VW-1:0] exp_q[$];
  logic [IW-1:0]    end_q[$];

  backend_dest_writeback_buffer #(
    .V_ID_WIDTH(IDW), .V_VALUE_WIDTH(VW), .ITERATION_WIDTH(IW),
    .V_OFF_AWIDTH(AW), .CORE_NUM_WIDTH(5), .FIFO_AWIDTH(FAW),
    .AFULL_MARGIN(4), .MERGE_MODE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .recv_update_v_id(recv_update_v_id),
    .recv_update_v_value(recv_update_v_value),
    .recv_update_v_valid(recv_update_v_valid),
    .recv_iteration_end(recv_iteration_end),
    .recv_iteration_end_valid(recv_iteration_end_valid),
    .recv_iteration_id(recv_iteration_id),
    .next_stage_full(next_stage_full),
    .dest_core_full(dest_core_full),
    .wr_vertex_bram_addr(wr_vertex_bram_addr),
    .wr_vertex_bram_data(wr_vertex_bram_data),
    .wr_vertex_bram_valid(wr_vertex_bram_valid),
    .wr_vertex_bram_iteration_end(wr_vertex_bram_iteration_end),
    .wr_vertex_bram_iteration_end_valid(wr_vertex_bram_iteration_end_valid),
    .wr_vertex_bram_iteration_id(wr_vertex_bram_iteration_id),
    .fifo_count(fifo_count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // One clock; outputs sampled 1ns after the edge and matched against the scoreboard.
  task automatic step();
    logic [AW+VW-1:0] e_w;
    logic [IW-1:0]    e_id;
    @(posedge clk);
    #1;
    if (wr_vertex_bram_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                 wr_vertex_bram_addr, wr_vertex_bram_data);
      end else begin
        e_w = exp_q.pop_front();
        if ({wr_vertex_bram_addr, wr_vertex_bram_data} !== e_w) begin
          failures++;
          $display("FAIL write_entry: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   wr_vertex_bram_addr, wr_vertex_bram_data, e_w[AW+VW-1:VW], e_w[VW-1:0]);
        end
      end
    end
    if (wr_vertex_bram_iteration_end) begin
      checks++;
      if (end_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_end: got end pulse id=%0d, required none",
                 wr_vertex_bram_iteration_id);
      end else begin
        e_id = end_q.pop_front();
        if (wr_vertex_bram_iteration_id !== e_id || wr_vertex_bram_iteration_end_valid !== 1'b1 ||
            wr_vertex_bram_valid !== 1'b0 || exp_q.size() != 0) begin
          failures++;
          $display("FAIL end_pulse: got id=%0d end_valid=%b wr_valid=%b pending_writes=%0d, required id=%0d end_valid=1 wr_valid=0 pending_writes=0",
                   wr_vertex_bram_iteration_id, wr_vertex_bram_iteration_end_valid,
                   wr_vertex_bram_valid, exp_q.size(), e_id);
        end
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || end_q.size() != 0) && n < 64) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || end_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got writes_left=%0d ends_left=%0d, required 0 and 0",
               name, exp_q.size(), end_q.size());
    end
  endtask

  task automatic set_update(input logic [IDW-1:0] id, input logic [VW-1:0] val);
    recv_update_v_id    = id;
    recv_update_v_value = val;
    recv_update_v_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_vertex_bram_valid, wr_vertex_bram_addr, wr_vertex_bram_data,
         wr_vertex_bram_iteration_end, wr_vertex_bram_iteration_end_valid,
         wr_vertex_bram_iteration_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b addr=%0h data=%0h end=%b id=%0d, required all 0",
               wr_vertex_bram_valid, wr_vertex_bram_addr, wr_vertex_bram_data,
               wr_vertex_bram_iteration_end, wr_vertex_bram_iteration_id);
    end
    checks++;
    if (fifo_count !== '0 || dest_core_full !== 1'b0 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got count=%0d full=%b ovf=%b, required 0 0 0",
               fifo_count, dest_core_full, overflow_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    set_update(16'h0045, 16'd7);
    exp_q.push_back({8'd2, 16'd7});
    step();
    recv_update_v_valid = 1'b0;
    checks++;
    if (wr_vertex_bram_valid !== 1'b0 || fifo_count !== 5'd1) begin
      failures++;
      $display("FAIL single_edgeN: got valid=%b count=%0d, required valid=0 count=1",
               wr_vertex_bram_valid, fifo_count);
    end
    step();
    checks++;
    if (wr_vertex_bram_valid !== 1'b1 || wr_vertex_bram_addr !== 8'd2 || wr_vertex_bram_data !== 16'd7) begin
      failures++;
      $display("FAIL single_write: got valid=%b addr=%0h data=%0h, required valid=1 addr=2 data=7",
               wr_vertex_bram_valid, wr_vertex_bram_addr, wr_vertex_bram_data);
    end
    step();
    checks++;
    if (wr_vertex_bram_valid !== 1'b0 || wr_vertex_bram_addr !== '0 || wr_vertex_bram_data !== '0) begin
      failures++;
      $display("FAIL single_idle: got valid=%b addr=%0h data=%0h, required 0 0 0",
               wr_vertex_bram_valid, wr_vertex_bram_addr, wr_vertex_bram_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      set_update(IDW'((40 + i) << 5), VW'(100 + i));
      exp_q.push_back({AW'(40 + i), VW'(100 + i)});
      step();
      checks++;
      if (fifo_count !== 5'd1 || dest_core_full !== 1'b0) begin
        failures++;
        $display("FAIL b2b_count[%0d]: got count=%0d full=%b, required count=1 full=0",
                 i, fifo_count, dest_core_full);
      end
    end
    recv_update_v_valid = 1'b0;
    drain("b2b");
  endtask

  task automatic test_merge();
    next_stage_full = 1'b1;
    set_update(16'h03E0, 16'd9); step();
    set_update(16'h03E0, 16'd3); step();
    set_update(16'h03E0, 16'd5); step();
    recv_update_v_valid = 1'b0;
    checks++;
    if (fifo_count !== 5'd1) begin
      failures++;
      $display("FAIL merge_count: got %0d, required 1", fifo_count);
    end
    exp_q.push_back({8'd31, 16'd3});
    next_stage_full = 1'b0;
    drain("merge");
    checks++;
    if (fifo_count !== 5'd0) begin
      failures++;
      $display("FAIL merge_empty: got %0d, required 0", fifo_count);
    end
  endtask

  task automatic test_fill_overflow();
    next_stage_full = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_update(IDW'((60 + i) << 5), VW'(i));
      if (i < 16) exp_q.push_back({AW'(60 + i), VW'(i)});
      step();
      if (i == 11) begin
        checks++;
        if (dest_core_full !== 1'b1 || fifo_count !== 5'd12) begin
          failures++;
          $display("FAIL fill_afull: got full=%b count=%0d, required full=1 count=12",
                   dest_core_full, fifo_count);
        end
      end
      if (i == 15) begin
        checks++;
        if (overflow_err !== 1'b0 || fifo_count !== 5'd16) begin
          failures++;
          $display("FAIL fill_16: got ovf=%b count=%0d, required ovf=0 count=16",
                   overflow_err, fifo_count);
        end
      end
    end
    recv_update_v_valid = 1'b0;
    checks++;
    if (overflow_err !== 1'b1 || fifo_count !== 5'd16) begin
      failures++;
      $display("FAIL overflow: got ovf=%b count=%0d, required ovf=1 count=16",
               overflow_err, fifo_count);
    end
    next_stage_full = 1'b0;
    drain("fill");
    checks++;
    if (fifo_count !== 5'd0 || dest_core_full !== 1'b0 || overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL fill_after: got count=%0d full=%b ovf=%b, required 0 0 1",
               fifo_count, dest_core_full, overflow_err);
    end
  endtask

  task automatic test_end_with_update();
    set_update(16'h0020, 16'h0011);
    recv_iteration_end = 1'b1; recv_iteration_end_valid = 1'b1; recv_iteration_id = 8'd4;
    exp_q.push_back({8'd1, 16'h0011});
    end_q.push_back(8'd4);
    step();
    recv_update_v_valid = 1'b0; recv_iteration_end = 1'b0; recv_iteration_end_valid = 1'b0;
    recv_iteration_id = 8'd0;
    drain("end_update");
    repeat (6) step();
    checks++;
    if (wr_vertex_bram_iteration_id !== 8'd4 || wr_vertex_bram_iteration_end !== 1'b0) begin
      failures++;
      $display("FAIL end_hold: got id=%0d end=%b, required id=4 end=0",
               wr_vertex_bram_iteration_id, wr_vertex_bram_iteration_end);
    end
  endtask

  task automatic test_end_absorb();
    next_stage_full = 1'b1;
    set_update(16'h0040, 16'h0022);
    recv_iteration_end = 1'b1; recv_iteration_end_valid = 1'b1; recv_iteration_id = 8'd5;
    step();
    recv_update_v_valid = 1'b0;
    recv_iteration_id = 8'd6;
    step();
    recv_iteration_end = 1'b0; recv_iteration_end_valid = 1'b0; recv_iteration_id = 8'd0;
    exp_q.push_back({8'd2, 16'h0022});
    end_q.push_back(8'd6);
    next_stage_full = 1'b0;
    drain("absorb");
    repeat (6) step();
    checks++;
    if (wr_vertex_bram_iteration_id !== 8'd6) begin
      failures++;
      $display("FAIL absorb_id: got %0d, required 6", wr_vertex_bram_iteration_id);
    end
  endtask

  task automatic test_reset_midburst();
    next_stage_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_update(IDW'((80 + i) << 5), VW'(200 + i));
      if (i == 4) begin
        recv_iteration_end = 1'b1; recv_iteration_end_valid = 1'b1; recv_iteration_id = 8'd9;
      end
      step();
    end
    recv_update_v_valid = 1'b0; recv_iteration_end = 1'b0; recv_iteration_end_valid = 1'b0;
    checks++;
    if (fifo_count !== 5'd5) begin
      failures++;
      $display("FAIL midburst_count: got %0d, required 5", fifo_count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_count !== '0 || dest_core_full !== 1'b0 || overflow_err !== 1'b0 ||
        wr_vertex_bram_iteration_id !== '0 || wr_vertex_bram_valid !== 1'b0 ||
        wr_vertex_bram_iteration_end !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got count=%0d full=%b ovf=%b id=%0d valid=%b end=%b, required all 0",
               fifo_count, dest_core_full, overflow_err, wr_vertex_bram_iteration_id,
               wr_vertex_bram_valid, wr_vertex_bram_iteration_end);
    end
    exp_q.delete();
    end_q.delete();
    @(negedge clk);
    rst = 1'b1;
    next_stage_full = 1'b0;
    repeat (8) step();
    checks++;
    if (fifo_count !== '0 || wr_vertex_bram_iteration_id !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: got count=%0d id=%0d, required 0 0",
               fifo_count, wr_vertex_bram_iteration_id);
    end
    set_update(16'h00A0, 16'h0055);
    exp_q.push_back({8'd5, 16'h0055});
    step();
    recv_update_v_valid = 1'b0;
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_merge();
    test_fill_overflow();
    test_end_with_update();
    test_end_absorb();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
